// File: rtl/seg_seven_pkg.sv
// Purpose: shared constants for the seven-segment capture block (pattern table, blank code, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seg_seven_pkg;

  // Active-low segment patterns, index = displayed nibble value (bit 0 = a ... bit 6 = g).
  localparam logic [0:15][6:0] SEG_PATTERNS = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // All segments off: a dark digit, not an error.
  localparam logic [6:0] BLANK_PATTERN = 7'h7F;

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/seg_seven_pattern_decode.sv
// Purpose: map one active-low segment pattern to nibble / blank / error flags.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module seg_seven_pattern_decode
  import seg_seven_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  logic hit;

  // Table lookup; blank and unknown patterns both report nibble 0.
  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    err    = 1'b0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_n == SEG_PATTERNS[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
    if (seg_n == BLANK_PATTERN) begin
      blank = 1'b1;
    end else if (!hit) begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/seg_seven_capture.sv
// Purpose: observe a multiplexed 7-segment display and rebuild the shown value frame by frame.
// Latency: STABLE_CYCLES samples to capture a digit, +1 cycle to frame_valid (+2 with SEG_SEVEN_CAPTURE_SYNC_EN).
// Backpressure: none; passive monitor, frames are overwritten if not consumed.
module seg_seven_capture
  import seg_seven_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    frame_valid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   err
);

  logic [NUM_DIGITS-1:0] an_smp;
  logic [6:0]            seg_smp;

`ifdef SEG_SEVEN_CAPTURE_SYNC_EN
  logic [NUM_DIGITS-1:0] an_s1_q, an_s1_d, an_s2_q, an_s2_d;
  logic [6:0]            seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;

  // Two-stage synchronizer shift for the asynchronous display lines.
  always_comb begin
    an_s1_d  = an_n;
    seg_s1_d = seg_n;
    an_s2_d  = an_s1_q;
    seg_s2_d = seg_s1_q;
  end

  // Synchronizer flops idle high (nothing selected, all segments dark).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q  <= '1;
      seg_s1_q <= '1;
      an_s2_q  <= '1;
      seg_s2_q <= '1;
    end else begin
      an_s1_q  <= an_s1_d;
      seg_s1_q <= seg_s1_d;
      an_s2_q  <= an_s2_d;
      seg_s2_q <= seg_s2_d;
    end
  end

  assign an_smp  = an_s2_q;
  assign seg_smp = seg_s2_q;
`else
  assign an_smp  = an_n;
  assign seg_smp = seg_n;
`endif

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic [7:0]              cnt_q, cnt_d;
  cap_state_t              state_q, state_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0]   sh_err_q, sh_err_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    frame_valid_q, frame_valid_d;

  logic [3:0] low_cnt;
  logic       sel;
  logic       change;
  logic       stable;
  logic       capture;
  logic [3:0] dec_nibble;
  logic       dec_blank;
  logic       dec_err;

  // Decode the previously sampled pattern: that is the one which proved stable.
  seg_seven_pattern_decode u_decode (
    .seg_n  (seg_q),
    .nibble (dec_nibble),
    .blank  (dec_blank),
    .err    (dec_err)
  );

  // Selection check, change detect and saturating stability counter.
  always_comb begin
    low_cnt = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      low_cnt = low_cnt + {3'b000, ~an_smp[i]};
    end
    sel    = (low_cnt == 4'd1);
    change = (an_smp != an_q) || (seg_smp != seg_q);
    an_d   = an_smp;
    seg_d  = seg_smp;
    if (change || !sel) begin
      cnt_d = 8'd0;
    end else if (cnt_q == 8'hFF) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    stable = sel && (cnt_d >= 8'(STABLE_CYCLES - 1));
  end

  // Dwell FSM: one capture per dwell. cnt_q == 0 in HOLD means the pair
  // changed during the CAPTURE cycle, so that new dwell must be counted too.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      SETTLE: begin
        if (stable) state_d = CAPTURE;
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (change || cnt_q == 8'd0) state_d = SETTLE;
      end
      default: state_d = SETTLE;
    endcase
  end

  // Shadow frame assembly and publish; a capture on the publish cycle opens the next frame.
  always_comb begin
    sh_val_d      = sh_val_q;
    sh_blank_d    = sh_blank_q;
    sh_err_d      = sh_err_q;
    seen_d        = seen_q;
    value_d       = value_q;
    blank_d       = blank_q;
    err_d         = err_q;
    frame_valid_d = 1'b0;
    if (&seen_q) begin
      value_d       = sh_val_q;
      blank_d       = sh_blank_q;
      err_d         = sh_err_q;
      frame_valid_d = 1'b1;
      seen_d        = '0;
    end
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!an_q[i]) begin
          sh_val_d[4*i +: 4] = dec_nibble;
          sh_blank_d[i]      = dec_blank;
          sh_err_d[i]        = dec_err;
          seen_d[i]          = 1'b1;
        end
      end
    end
  end

  // State registers; reset drops any partially assembled frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q          <= '1;
      seg_q         <= '1;
      cnt_q         <= 8'd0;
      state_q       <= SETTLE;
      seen_q        <= '0;
      sh_val_q      <= '0;
      sh_blank_q    <= '0;
      sh_err_q      <= '0;
      value_q       <= '0;
      blank_q       <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      an_q          <= an_d;
      seg_q         <= seg_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      seen_q        <= seen_d;
      sh_val_q      <= sh_val_d;
      sh_blank_q    <= sh_blank_d;
      sh_err_q      <= sh_err_d;
      value_q       <= value_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign value       = value_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seg_seven_capture.sv
// Purpose: directed scoreboard bench for seg_seven_capture (NUM_DIGITS=4, STABLE_CYCLES=4).
// Latency: expects frame_valid 6 cycles after the last dwell starts (8 with SEG_SEVEN_CAPTURE_SYNC_EN).
// Backpressure: none; monitor pops one expected frame per frame_valid pulse.
module tb_seg_seven_capture;

`ifdef SEG_SEVEN_CAPTURE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct {
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic [15:0] value;
  logic        frame_valid;
  logic [3:0]  blank;
  logic [3:0]  err;

  exp_t exp_q[$];
  int   cyc;
  int   vectors;
  int   miscompares;

  seg_seven_capture #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .value       (value),
    .frame_valid (frame_valid),
    .blank       (blank),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Hold one (an_n, seg_n) pair for n clock cycles, starting and ending on a falling edge.
  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    repeat (n) @(negedge clk);
  endtask

  // Called just before the dwell that completes a frame.
  task automatic expect_frame(input logic [15:0] v, input logic [3:0] b, input logic [3:0] e);
    exp_t x;
    x.value = v;
    x.blank = b;
    x.err   = e;
    x.cyc   = cyc + 6 + SYNC_LAT;
    exp_q.push_back(x);
  endtask

  // Monitor: every frame_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: value=0x%0h blank=%b err=%b at cycle %0d", value, blank, err, cyc);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("frame_value", 32'(value), 32'(x.value));
        check("frame_blank", 32'(blank), 32'(x.blank));
        check("frame_err",   32'(err),   32'(x.err));
        check("frame_cycle", 32'(cyc),   32'(x.cyc));
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    an_n  = 4'b1111;
    seg_n = 7'h7F;
    repeat (3) @(negedge clk);
    check("reset_value", 32'(value), 32'h0);
    check("reset_blank", 32'(blank), 32'h0);
    check("reset_err",   32'(err),   32'h0);
    check("reset_fv",    32'(frame_valid), 32'h0);
    rst_n = 1'b1;
    dwell(4'b1111, 7'h7F, 4);

    // Basic scan showing 4321.
    dwell(4'b1110, 7'h79, 8);
    dwell(4'b1101, 7'h24, 8);
    dwell(4'b1011, 7'h30, 8);
    expect_frame(16'h4321, 4'b0000, 4'b0000);
    dwell(4'b0111, 7'h19, 8);
    dwell(4'b1111, 7'h7F, 4);

    // Too-short dwell on digit 2: frame only completes on its later long dwell.
    dwell(4'b1110, 7'h79, 8);
    dwell(4'b1101, 7'h24, 8);
    dwell(4'b1011, 7'h30, 3);
    dwell(4'b0111, 7'h19, 8);
    expect_frame(16'h4321, 4'b0000, 4'b0000);
    dwell(4'b1011, 7'h30, 8);
    dwell(4'b1111, 7'h7F, 4);

    // Blank digit 1, undecodable digit 3.
    dwell(4'b1110, 7'h79, 8);
    dwell(4'b1101, 7'h7F, 8);
    dwell(4'b1011, 7'h30, 8);
    expect_frame(16'h0301, 4'b0010, 4'b1000);
    dwell(4'b0111, 7'h55, 8);
    dwell(4'b1111, 7'h7F, 4);

    // Two digits enabled at once, then none: nothing may be captured.
    dwell(4'b1100, 7'h19, 20);
    dwell(4'b1111, 7'h7F, 6);
    check("multi_sel_seen", 32'(dut.seen_q), 32'h0);

    // Reset after three captures discards them.
    dwell(4'b1110, 7'h79, 8);
    dwell(4'b1101, 7'h24, 8);
    dwell(4'b1011, 7'h30, 8);
    dwell(4'b1111, 7'h7F, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_value", 32'(value), 32'h0);
    check("midrst_blank", 32'(blank), 32'h0);
    check("midrst_err",   32'(err),   32'h0);
    check("midrst_fv",    32'(frame_valid), 32'h0);
    check("midrst_seen",  32'(dut.seen_q), 32'h0);
    rst_n = 1'b1;
    dwell(4'b1111, 7'h7F, 2);
    // Digit 3 alone must not complete a frame; digits 0..2 then finish it.
    dwell(4'b0111, 7'h03, 8);
    dwell(4'b1110, 7'h40, 8);
    dwell(4'b1101, 7'h0E, 8);
    expect_frame(16'hBAF0, 4'b0000, 4'b0000);
    dwell(4'b1011, 7'h08, 8);
    dwell(4'b1111, 7'h7F, 10);

    while (exp_q.size() != 0) begin
      exp_t x;
      x = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_frame: no frame_valid seen, expected value=0x%0h by cycle %0d", x.value, x.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
